rr_grant_ctrl: RTL and testbench
================================

// Module: rr_grant_ctrl
// PURPOSE
//  Round-robin arbiter sharing one resource among N requesters.
//  Registers a one-hot grant and its binary index. The index comes from a
//  one-hot-to-index encoder, which is the same conversion as our 8->3 log2 block.
//  Sits between requesting engines and the shared datapath it sequences.
//  Also provides a hold-time watchdog so that no owner can starve the others.
// PARAMETERS
//  N         8    number of requesters; power of two, 2..32
//  IDX_W     3    index width, = $clog2(N)
//  MAX_HOLD  16   max cycles per grant before forced release; 0 = no limit
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  req        in   N      request vector, level; bit i = requester i
//  done       in   1      owner finished; sampled only in GRANT
//  gnt        out  N      one-hot grant, registered; all-zero when idle
//  gnt_idx    out  IDX_W  binary index of set gnt bit; holds last value when idle
//  gnt_valid  out  1      =|gnt
//  timeout    out  1      one-cycle pulse, asserted on the forced-release edge
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, state=IDLE,
//   ptr=0, hold_cnt=0. Applies immediately, including mid-grant.
//  States: IDLE, GRANT.
//  IDLE:
//   - If req==0, stay in IDLE.
//   - Else grant the first set req bit scanning circularly from ptr upward
//     (ptr, ptr+1 .. N-1, 0 .. ptr-1).
//   - gnt, gnt_idx and gnt_valid update on that edge; latency is 1 cycle req->gnt.
//   - Go to GRANT; hold_cnt=0.
//   - done is ignored in IDLE.
//  GRANT:
//   - gnt and gnt_idx are held stable; hold_cnt increments each cycle, saturating.
//   - Release condition (any of):
//     a) done=1
//     b) req[gnt_idx]=0 (requester withdrew)
//     c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
//   - On release edge: gnt=0, gnt_valid=0, ptr=(gnt_idx+1) mod N (N-1 wraps to 0),
//     state=IDLE.
//   - timeout=1 on that edge only if c) holds and neither a) nor b) does.
//  Grant spacing:
//   - Exactly one idle cycle (gnt_valid=0) between consecutive grants.
//   - The arbitration decision is made in IDLE using req sampled then; requests
//     changing during GRANT have no effect until IDLE.
//  Fairness: a requester holding req high is granted within N grants.
//  Invariants: gnt is zero or one-hot; gnt_idx==encode(gnt) whenever gnt_valid.
//  hold_cnt width: $clog2(MAX_HOLD+1), minimum 1.
//  timeout is 0 in every cycle other than the forced-release edge.
// STRUCTURE
//  Shared package rr_pkg:
//   - state enum {IDLE, GRANT}
//   - localparam for default N/IDX_W
//  Sub-module onehot_to_index (N, IDX_W): combinational one-hot -> binary.
//   - Output 0 for all-zero input.
//   - Used on the chosen grant vector.
//  Arbitration: rotate req right by ptr, priority-pick the lowest bit,
//   then rotate left by ptr. Keep this in the top module.
// TESTING
//  1 Reset: rst_n=0 with req=8'hFF -> gnt=0, gnt_valid=0, timeout=0.
//    Release reset -> next edge gnt=8'h01, gnt_idx=0.
//  2 Rotation: req=8'hFF held, done pulsed each GRANT -> gnt_idx sequence
//    0,1,..,7,0, with a 1-cycle gap each.
//  3 Skip and wrap: ptr=6 (after a grant to 5), req=8'b0000_0101
//    -> gnt=8'h01, gnt_idx=0.
//  4 Timeout: MAX_HOLD=16, req=8'h08 held, done=0 -> gnt=8'h08 for 16 cycles,
//    then timeout=1 for 1 cycle; after re-grant, hold_cnt restarts at 0.
//  5 Withdraw: owner idx 2 drops req mid-grant -> gnt=0 next edge, timeout=0,
//    ptr=3.
//  6 Async reset mid-grant: rst_n low between edges -> gnt=0 without waiting
//    for clk; after release, ptr=0.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared state type and default sizing for the round-robin grant controller.
package rr_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_e;

  localparam int RR_N_DEF     = 8;
  localparam int RR_IDX_W_DEF = $clog2(RR_N_DEF);

endpackage

// File: rtl/rr_grant_ctrl_onehot_to_index.sv
// One-hot to binary index encoder (same conversion as the 8->3 log2 block).
// All-zero input encodes to index 0.
module onehot_to_index
  import rr_pkg::*;
#(
  parameter int N     = RR_N_DEF,
  parameter int IDX_W = RR_IDX_W_DEF
) (
  input  logic [N-1:0]     i_onehot,
  output logic [IDX_W-1:0] o_idx
);

  // OR together the indices of all set bits; exact for a one-hot input.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      o_idx = o_idx | (i_onehot[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter with registered one-hot grant, binary index and a
// hold-time watchdog that forces release after MAX_HOLD cycles.
module rr_grant_ctrl
  import rr_pkg::*;
#(
  parameter int N        = RR_N_DEF,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_done,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_valid,
  output logic             o_timeout
);

  localparam int HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? HC_W'(0) : HC_W'(MAX_HOLD - 1);

  rr_state_e        r_state;
  logic [N-1:0]     r_gnt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_gnt_valid;
  logic             r_timeout;
  logic [IDX_W-1:0] r_ptr;
  logic [HC_W-1:0]  r_hold;

  rr_state_e        w_state_nxt;
  logic [N-1:0]     w_gnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [HC_W-1:0]  w_hold_nxt;
  logic             w_timeout_nxt;

  logic [N-1:0]     w_req_rot;
  logic [N-1:0]     w_pick_rot;
  logic [N-1:0]     w_pick_gnt;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_limit;
  logic             w_release;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  // N is a power of two, so IDX_W-bit index arithmetic wraps modulo N.
  always_comb begin
    w_req_rot  = '0;
    w_pick_gnt = '0;
    for (int i = 0; i < N; i++) begin
      w_req_rot[i] = i_req[IDX_W'(i) + r_ptr];
    end
    w_pick_rot = w_req_rot & (~w_req_rot + N'(1));
    for (int i = 0; i < N; i++) begin
      w_pick_gnt[i] = w_pick_rot[IDX_W'(i) - r_ptr];
    end
  end

  onehot_to_index #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .i_onehot (w_pick_gnt),
    .o_idx    (w_pick_idx)
  );

  assign w_limit   = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);
  assign w_release = i_done | ~i_req[r_gnt_idx] | w_limit;

  // Next-state and next-output decode for the IDLE/GRANT controller.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_idx_nxt     = r_gnt_idx;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (|i_req) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_pick_gnt;
          w_idx_nxt   = w_pick_idx;
          w_hold_nxt  = '0;
        end else begin
          w_gnt_nxt = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_nxt   = IDLE;
          w_gnt_nxt     = '0;
          w_ptr_nxt     = r_gnt_idx + IDX_W'(1);
          // Flag only a release caused purely by the watchdog.
          w_timeout_nxt = w_limit & i_req[r_gnt_idx] & ~i_done;
        end else begin
          w_hold_nxt = (r_hold == {HC_W{1'b1}}) ? r_hold : r_hold + HC_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_ptr       <= '0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_gnt_valid <= |w_gnt_nxt;
      r_timeout   <= w_timeout_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold      <= w_hold_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_idx   = r_gnt_idx;
  assign o_gnt_valid = r_gnt_valid;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a scan model.
module tb_rr_grant_ctrl;

  localparam int N        = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic             done = 1'b0;
  logic [N-1:0]     o_gnt;
  logic [IDX_W-1:0] o_gnt_idx;
  logic             o_gnt_valid;
  logic             o_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: who owns the resource, where the scan starts, and how long held.
  bit m_busy    = 1'b0;
  int m_owner   = 0;
  int m_ptr     = 0;
  int m_hold    = 0;
  bit m_timeout = 1'b0;
  int t_pick;
  bit t_d, t_w, t_l;

  rr_grant_ctrl #(
    .N        (N),
    .IDX_W    (IDX_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (req),
    .i_done      (done),
    .o_gnt       (o_gnt),
    .o_gnt_idx   (o_gnt_idx),
    .o_gnt_valid (o_gnt_valid),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: circular first-fit scan from ptr; release on done, withdraw or hold limit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_owner <= 0; m_ptr <= 0; m_hold <= 0; m_timeout <= 1'b0;
    end else begin
      m_timeout <= 1'b0;
      if (!m_busy) begin
        if (req != '0) begin
          t_pick = -1;
          for (int k = N - 1; k >= 0; k--) begin
            if (req[(m_ptr + k) % N]) t_pick = (m_ptr + k) % N;
          end
          m_busy <= 1'b1; m_owner <= t_pick; m_hold <= 0;
        end
      end else begin
        t_d = done;
        t_w = !req[m_owner];
        t_l = (MAX_HOLD != 0) && (m_hold == MAX_HOLD - 1);
        if (t_d || t_w || t_l) begin
          m_busy    <= 1'b0;
          m_ptr     <= (m_owner + 1) % N;
          m_timeout <= t_l && !t_d && !t_w;
        end else begin
          m_hold <= m_hold + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_gnt", 32'(o_gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
      chk("model_idx", 32'(o_gnt_idx), 32'(m_owner));
      chk("model_valid", 32'(o_gnt_valid), 32'(m_busy));
      chk("model_timeout", 32'(o_timeout), 32'(m_timeout));
    end
  end

  task automatic wait_idx(input int idx, input int lim);
    int c = 0;
    while (!(o_gnt_valid && int'(o_gnt_idx) == idx) && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk("wait_grant", 32'(c < lim), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rec, cnt, guard;
    bit prev_v;
    req  = 8'hFF;
    done = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_gnt", 32'(o_gnt), 32'h0);
    chk("rst_valid", 32'(o_gnt_valid), 32'h0);
    chk("rst_timeout", 32'(o_timeout), 32'h0);
    chk("rst_idx", 32'(o_gnt_idx), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_gnt", 32'(o_gnt), 32'h01);
    chk("first_idx", 32'(o_gnt_idx), 32'h0);

    // Rotation with done pulsed in every grant cycle.
    rec = 0; prev_v = 1'b0; guard = 0;
    while (rec < 9 && guard < 60) begin
      if (o_gnt_valid) begin
        if (!prev_v) begin
          chk("rot_seq", 32'(o_gnt_idx), 32'(rec % 8));
          rec++;
        end
        done = 1'b1;
      end else begin
        done = 1'b0;
      end
      prev_v = o_gnt_valid;
      guard++;
      if (rec < 9) @(negedge clk);
    end
    chk("rot_count", 32'(rec), 32'd9);

    // Skip and wrap: grant 5, withdraw it, then only 0 and 2 request.
    @(negedge clk);
    done = 1'b0;
    req  = 8'h20;
    wait_idx(5, 10);
    req = 8'h05;
    @(negedge clk);
    chk("wrap_gap", 32'(o_gnt_valid), 32'h0);
    @(negedge clk);
    chk("wrap_gnt", 32'(o_gnt), 32'h01);
    chk("wrap_idx", 32'(o_gnt_idx), 32'h0);

    // Watchdog: requester 3 holds forever, twice in a row.
    req = 8'h08;
    wait_idx(3, 10);
    for (int r = 0; r < 2; r++) begin
      cnt = 0;
      while (o_gnt == 8'h08 && cnt < 40) begin
        cnt++;
        @(negedge clk);
      end
      chk("hold_len", 32'(cnt), 32'd16);
      chk("timeout_pulse", 32'(o_timeout), 32'h1);
      chk("timeout_gnt", 32'(o_gnt), 32'h0);
      if (r == 0) begin
        @(negedge clk);
        chk("timeout_clear", 32'(o_timeout), 32'h0);
        chk("regrant_gnt", 32'(o_gnt), 32'h08);
      end else begin
        req = 8'h04;
      end
    end

    // Withdraw: owner 2 drops its request while others keep asking.
    wait_idx(2, 12);
    @(negedge clk);
    req = 8'hFB;
    @(negedge clk);
    chk("wd_gnt", 32'(o_gnt), 32'h0);
    chk("wd_timeout", 32'(o_timeout), 32'h0);
    @(negedge clk);
    chk("wd_next_idx", 32'(o_gnt_idx), 32'h3);
    chk("wd_next_gnt", 32'(o_gnt), 32'h08);

    // Asynchronous reset between edges while granted.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(o_gnt), 32'h0);
    chk("arst_valid", 32'(o_gnt_valid), 32'h0);
    chk("arst_idx", 32'(o_gnt_idx), 32'h0);
    @(negedge clk);
    req = 8'h81;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ptr_gnt", 32'(o_gnt), 32'h01);

    // Randomized traffic; requests change only occasionally so the watchdog fires.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) req = 8'($urandom) & 8'($urandom);
        else req = 8'($urandom);
      end
      done = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
